// File: rtl/knn_list.sv
// Sorted K-nearest-neighbour list with single-cycle stable insertion.
// Define KNN_VOTE_EN to add the multi-cycle majority-vote FSM and its ports.
module knn_list #(
    parameter int DATA_W  = 32,
    parameter int NBR_KNN = 4,
    parameter int LABEL_W = 8,
    parameter int SEL_W   = $clog2(NBR_KNN),
    parameter int CNT_W   = $clog2(NBR_KNN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               valid,
    input  logic [DATA_W-1:0]  distance,
    input  logic [LABEL_W-1:0] label,
    input  logic [SEL_W-1:0]   sel,
    output logic [DATA_W-1:0]  knn_dist,
    output logic [LABEL_W-1:0] knn_label,
    output logic [CNT_W-1:0]   count
`ifdef KNN_VOTE_EN
    ,
    input  logic               finish,
    output logic               busy,
    output logic               vote_valid,
    output logic [LABEL_W-1:0] vote_label
`endif
);

    logic [DATA_W-1:0]  dist_q [NBR_KNN];
    logic [DATA_W-1:0]  dist_d [NBR_KNN];
    logic [LABEL_W-1:0] lab_q  [NBR_KNN];
    logic [LABEL_W-1:0] lab_d  [NBR_KNN];
    logic [NBR_KNN-1:0] vld_q, vld_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [NBR_KNN-1:0] le;
    logic               accept;
    logic               vote_hold;

    // le[] is a prefix mask because the valid entries are sorted and contiguous;
    // the first clear bit is the insertion slot, and all-set means "discard".
    always_comb begin
        le = '0;
        for (int i = 0; i < NBR_KNN; i++) begin
            le[i] = vld_q[i] && (dist_q[i] <= distance);
        end
        accept  = valid && !clear && !vote_hold && !(&le);
        dist_d  = dist_q;
        lab_d   = lab_q;
        vld_d   = vld_q;
        count_d = count_q;
        if (accept) begin
            if (!le[0]) begin
                dist_d[0] = distance;
                lab_d[0]  = label;
                vld_d[0]  = 1'b1;
            end
            for (int i = 1; i < NBR_KNN; i++) begin
                if (!le[i]) begin
                    if (le[i-1]) begin
                        dist_d[i] = distance;
                        lab_d[i]  = label;
                        vld_d[i]  = 1'b1;
                    end else begin
                        dist_d[i] = dist_q[i-1];
                        lab_d[i]  = lab_q[i-1];
                        vld_d[i]  = vld_q[i-1];
                    end
                end
            end
            if (count_q != CNT_W'(NBR_KNN)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_q[i] <= '1;
                lab_q[i]  <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_q[i] <= '1;
                lab_q[i]  <= '0;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NBR_KNN; i++) begin
                dist_q[i] <= dist_d[i];
                lab_q[i]  <= lab_d[i];
            end
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    // Guarded read: sel past the occupancy returns the cleared values.
    always_comb begin
        knn_dist  = '1;
        knn_label = '0;
        if (CNT_W'(sel) < count_q) begin
            knn_dist  = dist_q[sel];
            knn_label = lab_q[sel];
        end
    end

    assign count = count_q;

`ifdef KNN_VOTE_EN
    typedef enum logic {S_IDLE, S_VOTE} state_t;

    state_t             state_q;
    logic [SEL_W-1:0]   idx_q;
    logic [CNT_W-1:0]   best_q;
    logic [CNT_W-1:0]   match_cnt;
    logic               busy_q, vote_valid_q;
    logic [LABEL_W-1:0] vote_label_q;

    always_comb begin
        match_cnt = '0;
        for (int j = 0; j < NBR_KNN; j++) begin
            if (vld_q[j] && (lab_q[j] == lab_q[idx_q])) begin
                match_cnt = match_cnt + CNT_W'(1);
            end
        end
    end

    // Strict '>' keeps the earliest (nearest) label on equal counts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            best_q       <= '0;
            busy_q       <= 1'b0;
            vote_valid_q <= 1'b0;
            vote_label_q <= '0;
        end else if (clear) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            vote_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (finish) begin
                        state_q      <= S_VOTE;
                        idx_q        <= '0;
                        best_q       <= '0;
                        busy_q       <= 1'b1;
                        vote_valid_q <= 1'b0;
                        vote_label_q <= '0;
                    end
                end
                S_VOTE: begin
                    if (vld_q[idx_q] && (match_cnt > best_q)) begin
                        best_q       <= match_cnt;
                        vote_label_q <= lab_q[idx_q];
                    end
                    if (idx_q == SEL_W'(NBR_KNN - 1)) begin
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        vote_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + SEL_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign vote_hold  = (state_q == S_VOTE);
    assign busy       = busy_q;
    assign vote_valid = vote_valid_q;
    assign vote_label = vote_label_q;
`else
    assign vote_hold = 1'b0;
`endif

endmodule

// File: tb/tb_knn_list.sv
// Self-checking bench for knn_list; vote scenarios compile in with KNN_VOTE_EN.
module tb_knn_list;

    localparam int DATA_W  = 32;
    localparam int NBR_KNN = 4;
    localparam int LABEL_W = 8;
    localparam int SEL_W   = $clog2(NBR_KNN);
    localparam int CNT_W   = $clog2(NBR_KNN + 1);
    localparam int EW      = DATA_W + LABEL_W;
    localparam int EXP_W   = NBR_KNN * EW + CNT_W;

    logic               clk;
    logic               rst;
    logic               clear;
    logic               valid;
    logic [DATA_W-1:0]  distance;
    logic [LABEL_W-1:0] label;
    logic [SEL_W-1:0]   sel;
    logic [DATA_W-1:0]  knn_dist;
    logic [LABEL_W-1:0] knn_label;
    logic [CNT_W-1:0]   count;
`ifdef KNN_VOTE_EN
    logic               finish;
    logic               busy;
    logic               vote_valid;
    logic [LABEL_W-1:0] vote_label;
`endif

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    logic [DATA_W-1:0]  m_dist [NBR_KNN];
    logic [LABEL_W-1:0] m_lab  [NBR_KNN];
    int                 m_cnt;

    knn_list #(
        .DATA_W (DATA_W),
        .NBR_KNN(NBR_KNN),
        .LABEL_W(LABEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .valid    (valid),
        .distance (distance),
        .label    (label),
        .sel      (sel),
        .knn_dist (knn_dist),
        .knn_label(knn_label),
        .count    (count)
`ifdef KNN_VOTE_EN
        ,
        .finish    (finish),
        .busy      (busy),
        .vote_valid(vote_valid),
        .vote_label(vote_label)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: plain sorted array with stable insertion
    task automatic model_clear();
        for (int i = 0; i < NBR_KNN; i++) begin
            m_dist[i] = '1;
            m_lab[i]  = '0;
        end
        m_cnt = 0;
    endtask

    task automatic model_insert(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
        int p;
        p = 0;
        while (p < m_cnt && m_dist[p] <= d) p++;
        if (p < NBR_KNN) begin
            for (int i = NBR_KNN - 1; i > p; i--) begin
                m_dist[i] = m_dist[i-1];
                m_lab[i]  = m_lab[i-1];
            end
            m_dist[p] = d;
            m_lab[p]  = l;
            if (m_cnt < NBR_KNN) m_cnt++;
        end
    endtask

    task automatic push_model();
        logic [EXP_W-1:0] e;
        e = '0;
        for (int i = 0; i < NBR_KNN; i++) begin
            e[i*EW +: EW] = {m_dist[i], m_lab[i]};
        end
        e[NBR_KNN*EW +: CNT_W] = CNT_W'(m_cnt);
        exp_q.push_back(e);
    endtask

    // Scoreboard: pop one expected snapshot and compare every entry plus count
    task automatic sb_check(input string name);
        logic [EXP_W-1:0]   e;
        logic [DATA_W-1:0]  ed;
        logic [LABEL_W-1:0] el;
        logic [CNT_W-1:0]   ec;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e  = exp_q.pop_front();
            ec = e[NBR_KNN*EW +: CNT_W];
            if (count !== ec) begin
                errors++;
                $display("FAIL %s count got %0d exp %0d", name, count, ec);
            end
            for (int s = 0; s < NBR_KNN; s++) begin
                sel = SEL_W'(s);
                #1;
                ed = e[s*EW + LABEL_W +: DATA_W];
                el = e[s*EW +: LABEL_W];
                checks++;
                if (knn_dist !== ed || knn_label !== el) begin
                    errors++;
                    $display("FAIL %s sel%0d got %h/%0d exp %h/%0d", name, s, knn_dist, knn_label, ed, el);
                end
            end
        end
    endtask

    // Driver: one cycle of stimulus, model update, then check after the edge
    task automatic drive_cycle(input string name, input logic v, input logic c,
                               input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l);
        @(negedge clk);
        valid    = v;
        clear    = c;
        distance = d;
        label    = l;
        if (c) model_clear();
        else if (v) model_insert(d, l);
        push_model();
        @(posedge clk);
        #1;
        sb_check(name);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        model_clear();
        push_model();
        sb_check("reset_async");
        @(negedge clk);
        rst = 1'b0;
        push_model();
        sb_check("reset_release");
    endtask

    task automatic test_basic();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("basic50", 1'b1, 1'b0, 50, 1);
        drive_cycle("basic10", 1'b1, 1'b0, 10, 2);
        drive_cycle("basic30", 1'b1, 1'b0, 30, 3);
        idle();
        checks++;
        sel = 2'd3;
        #1;
        if (knn_dist !== 32'hFFFF_FFFF || knn_label !== 8'd0 || count !== 3'd3) begin
            errors++;
            $display("FAIL basic_sel3 got %h/%0d cnt %0d exp ffffffff/0 cnt 3", knn_dist, knn_label, count);
        end
    endtask

    task automatic test_full_insert();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("full10", 1'b1, 1'b0, 10, 1);
        drive_cycle("full20", 1'b1, 1'b0, 20, 2);
        drive_cycle("full30", 1'b1, 1'b0, 30, 3);
        drive_cycle("full40", 1'b1, 1'b0, 40, 4);
        drive_cycle("full25", 1'b1, 1'b0, 25, 9);
        drive_cycle("full30_drop", 1'b1, 1'b0, 30, 5);
        drive_cycle("full_big_drop", 1'b1, 1'b0, 32'hFFFF_FFFF, 6);
        drive_cycle("full5", 1'b1, 1'b0, 5, 7);
        idle();
    endtask

    task automatic test_tie();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("tie_a", 1'b1, 1'b0, 10, 1);
        drive_cycle("tie_b", 1'b1, 1'b0, 10, 2);
        drive_cycle("clr_and_valid", 1'b1, 1'b1, 3, 3);
        idle();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL clr_valid_count got %0d exp 0", count);
        end
    endtask

    task automatic test_all_ones();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("ones_a", 1'b1, 1'b0, 32'hFFFF_FFFF, 8'hAA);
        drive_cycle("ones_b", 1'b1, 1'b0, 32'hFFFF_FFFF, 8'hBB);
        drive_cycle("ones_c", 1'b1, 1'b0, 0, 8'hCC);
        idle();
    endtask

    task automatic test_back_to_back();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            drive_cycle("b2b", 1'b1, 1'b0, DATA_W'(60 - 10 * i), LABEL_W'(i + 1));
        end
        idle();
        checks++;
        sel = 2'd0;
        #1;
        if (knn_dist !== 32'd10 || count !== 3'd4) begin
            errors++;
            $display("FAIL b2b_final got %0d cnt %0d exp 10 cnt 4", knn_dist, count);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        for (int i = 0; i < 30; i++) begin
            d = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : DATA_W'($urandom_range(0, 12));
            drive_cycle("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 14) == 0,
                        d, LABEL_W'($urandom_range(0, 255)));
        end
        idle();
    endtask

    task automatic test_async_reset_list();
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("ar_a", 1'b1, 1'b0, 7, 1);
        idle();
        #3;
        rst = 1'b1;
        sel = 2'd0;
        #1;
        checks++;
        if (count !== 3'd0 || knn_dist !== 32'hFFFF_FFFF || knn_label !== 8'd0) begin
            errors++;
            $display("FAIL async_rst_list got cnt %0d %h/%0d exp 0 ffffffff/0", count, knn_dist, knn_label);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef KNN_VOTE_EN
    task automatic load4(input logic [LABEL_W-1:0] l0, input logic [LABEL_W-1:0] l1,
                         input logic [LABEL_W-1:0] l2, input logic [LABEL_W-1:0] l3);
        drive_cycle("clr", 1'b0, 1'b1, 0, 0);
        drive_cycle("ld", 1'b1, 1'b0, 40, l3);
        drive_cycle("ld", 1'b1, 1'b0, 10, l0);
        drive_cycle("ld", 1'b1, 1'b0, 30, l2);
        drive_cycle("ld", 1'b1, 1'b0, 20, l1);
        idle();
    endtask

    task automatic run_vote(input string name, input logic [LABEL_W-1:0] exp_label);
        @(negedge clk);
        finish = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NBR_KNN; k++) begin
            checks++;
            if (busy !== 1'b1 || vote_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_c%0d got busy %b vv %b exp 1 0", name, k, busy, vote_valid);
            end
            @(negedge clk);
            finish   = 1'b0;
            valid    = 1'b1;
            distance = 1;
            label    = 8'hEE;
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || vote_valid !== 1'b1 || vote_label !== exp_label) begin
            errors++;
            $display("FAIL %s result got busy %b vv %b lab %0d exp 0 1 %0d", name, busy, vote_valid, vote_label, exp_label);
        end
        idle();
        checks++;
        if (vote_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s hold got vv %b exp 1", name, vote_valid);
        end
        push_model();
        sb_check("vote_drop_valid");
    endtask

    task automatic test_vote();
        load4(7, 3, 7, 3);
        run_vote("vote_7373", 7);
        load4(3, 7, 7, 5);
        run_vote("vote_3775", 7);
        drive_cycle("clr_empty", 1'b0, 1'b1, 0, 0);
        idle();
        run_vote("vote_empty", 0);
    endtask

    task automatic test_vote_abort();
        load4(1, 2, 2, 1);
        @(negedge clk);
        finish = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        finish = 1'b0;
        clear  = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || vote_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL vote_clear got busy %b vv %b cnt %0d exp 0 0 0", busy, vote_valid, count);
        end
        idle();
        load4(4, 4, 2, 1);
        @(negedge clk);
        finish = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        finish = 1'b0;
        #4;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || vote_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL vote_async_rst got busy %b vv %b cnt %0d exp 0 0 0", busy, vote_valid, count);
        end
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask
`endif

    initial begin
        clear    = 1'b0;
        valid    = 1'b0;
        distance = '0;
        label    = '0;
        sel      = '0;
`ifdef KNN_VOTE_EN
        finish   = 1'b0;
`endif
        test_reset();
        test_basic();
        test_full_insert();
        test_tie();
        test_all_ones();
        test_back_to_back();
        test_random();
        test_async_reset_list();
`ifdef KNN_VOTE_EN
        test_vote();
        test_vote_abort();
`endif
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover %0d entries exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knn_list.md
# knn_list

Sorted K-nearest-neighbour list stage. It sits directly downstream of the distance stage and consumes one distance per data point, together with that data point's class label. It keeps the NBR_KNN smallest distances seen since the last clear, in ascending order, using single-cycle insertion. Optionally it runs a multi-cycle majority vote over the stored labels to classify the current test point.

## Interface
- DATA_W, 32, distance width (unsigned squared distance from the distance stage)
- NBR_KNN, 4, list depth K (≥2)
- LABEL_W, 8, class label width
- SEL_W, $clog2(NBR_KNN), read-select width
- CNT_W, $clog2(NBR_KNN+1), occupancy width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous list clear (start of a new test point)
- valid  in  1  distance/label sample strobe
- distance  in  DATA_W  unsigned distance of the current data point
- label  in  LABEL_W  class label of the current data point
- sel  in  SEL_W  read index, 0 = nearest
- knn_dist  out  DATA_W  distance of entry sel (combinational read of registered list)
- knn_label  out  LABEL_W  label of entry sel
- count  out  CNT_W  number of valid entries, saturates at NBR_KNN
- finish  in  1  start vote (KNN_VOTE_EN only)
- busy  out  1  vote in progress (KNN_VOTE_EN only)
- vote_valid  out  1  vote result valid, level (KNN_VOTE_EN only)
- vote_label  out  LABEL_W  majority label (KNN_VOTE_EN only)

## Operation
- Storage: per entry i, dist[i], lab[i] and vld[i]. Entries 0..count-1 are valid and ascending in distance. Entries are contiguous: vld[i] implies vld[i-1].
- Reset and clear set every dist to all-ones, every lab to 0, every vld to 0 and count to 0.
- Insertion on valid (and not clear): p = number of valid entries with dist[i] ≤ distance. Ties therefore place the new entry after existing equal ones (stable).
  - p < NBR_KNN: entries p..K-2 shift to p+1..K-1 and entry p takes {distance, label}. Entry K-1 is lost when full. count increments, saturating at NBR_KNN.
  - p = NBR_KNN (full and distance ≥ every entry): sample discarded, no state change.
- A distance of all-ones is a legal value and is inserted normally, because comparison is gated by vld.
- clear has priority over valid in the same cycle: the list is cleared and the sample dropped.
- sel ≥ count returns the cleared values (all-ones, 0).

## Timing
- Insertion latency is 1 cycle: the sample at edge t is visible on knn_dist/knn_label/count after edge t.
- valid may be asserted every cycle, with no back-pressure in the non-vote build.
- Async rst forces all registers and outputs to their reset values immediately, independent of clk.
- Reset values: knn_dist = all-ones, knn_label = 0, count = 0, busy = 0, vote_valid = 0, vote_label = 0.

## Configuration
- KNN_VOTE_EN defined: the vote FSM and the ports finish/busy/vote_valid/vote_label are present.
  - States: IDLE, VOTE.
  - IDLE, finish=1 → VOTE, idx=0, best_cnt=0, vote_valid=0.
  - In each VOTE cycle, c = count of valid entries j with lab[j]==lab[idx]. If vld[idx] and c > best_cnt, then best_cnt=c and vote_label=lab[idx]. Strict > means the tie goes to the lowest index, i.e. the nearest neighbour.
  - After the idx=NBR_KNN-1 cycle → IDLE, vote_valid=1.
  - busy=1 exactly in VOTE.
  - vote_valid rises NBR_KNN cycles after the edge sampling finish. It holds until the next finish, clear or rst.
  - Empty list: vote_label=0, vote_valid=1 after the same latency.
  - During VOTE: valid samples are dropped and finish is ignored. clear aborts the vote to IDLE (vote_valid=0) and clears the list.
- KNN_VOTE_EN undefined: none of these ports or the FSM exist; the list behaves identically.

## Test plan
- Reset, insert 50/l1, 10/l2, 30/l3 → sel 0..3 reads 10/2, 30/3, 50/1, FFFFFFFF/0; count=3.
- Full list 10,20,30,40, insert 25/l9 → 10,20,25,30, count=4. Then insert 30/l5 → 10,20,25,30(old),30/l5 is dropped: entry 3 stays the old label.
- Tie: insert 10/l1, then 10/l2 → entry0 l1, entry1 l2. clear and valid in the same cycle → count=0 next cycle.
- Back-to-back valid for 6 cycles with 60,50,40,30,20,10 → list 10,20,30,40, count=4 one cycle after the last sample.
- KNN_VOTE_EN, K=4, labels by distance 7,3,7,3 → finish → busy 4 cycles, vote_label=7 (tie goes to nearest). Labels 3,7,7,5 → 7.
- KNN_VOTE_EN: assert rst asynchronously mid-VOTE → busy, vote_valid and count drop at once, with no clk edge needed. clear mid-VOTE → IDLE and vote_valid=0.
